// File: rtl/memory_pkg.sv
// memory_pkg: shared types and elaboration helpers for the memory bank
package memory_pkg;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   function automatic int lanes(input int word_size, input int lane_width);
      return word_size / lane_width;
   endfunction

   function automatic bit latency_ok(input int lat);
      return lat == 1 || lat == 2;
   endfunction

endpackage

// File: rtl/memory_bank_if.sv
// memory_bank_if: request/response bus between the load-store unit and the memory bank
interface memory_bank_if
   import memory_pkg::*;
#(
   parameter int WORD_SIZE  = 16,
   parameter int LANE_WIDTH = 8
);
   localparam int LANES = lanes(WORD_SIZE, LANE_WIDTH);

   logic                 REQ;
   logic                 W;
   logic [WORD_SIZE-1:0] ADDR;
   logic [LANES-1:0]     BE;
   logic [WORD_SIZE-1:0] DATA_IN;
   logic                 READY;
   logic [WORD_SIZE-1:0] DATA_OUT;
   logic                 VALID;
   logic                 ERR;

   modport master (
      output REQ, W, ADDR, BE, DATA_IN,
      input  READY, DATA_OUT, VALID, ERR
   );

   modport slave (
      input  REQ, W, ADDR, BE, DATA_IN,
      output READY, DATA_OUT, VALID, ERR
   );

endinterface

// File: rtl/memory_bank_read_pipe.sv
// read_pipe: fixed-depth delay line for read results; data holds while no result moves through
module read_pipe #(
   parameter int W     = 16,
   parameter int DEPTH = 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         v_in,
   input  logic         e_in,
   input  logic [W-1:0] d_in,
   output logic         v_out,
   output logic         e_out,
   output logic [W-1:0] d_out
);

   logic [DEPTH-1:0] v_q, v_d, e_q, e_d;
   logic [W-1:0]     d_q [DEPTH];
   logic [W-1:0]     d_d [DEPTH];

   // shift valid/err every cycle; each stage only takes new data when a result arrives
   always_comb begin
      v_d    = v_q;
      e_d    = e_q;
      d_d    = d_q;
      v_d[0] = v_in;
      e_d[0] = e_in;
      d_d[0] = v_in ? d_in : d_q[0];
      for (int i = 1; i < DEPTH; i++) begin
         v_d[i] = v_q[i-1];
         e_d[i] = e_q[i-1];
         d_d[i] = v_q[i-1] ? d_q[i-1] : d_q[i];
      end
   end

   // stage registers, flushed so no stale result survives a reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         v_q <= '0;
         e_q <= '0;
         d_q <= '{default: '0};
      end else begin
         v_q <= v_d;
         e_q <= e_d;
         d_q <= d_d;
      end
   end

   assign v_out = v_q[DEPTH-1];
   assign e_out = e_q[DEPTH-1];
   assign d_out = d_q[DEPTH-1];

endmodule

// File: rtl/memory_bank.sv
// memory_bank: single-port word memory with byte lanes, range checking and post-reset clear
module memory_bank
   import memory_pkg::*;
#(
   parameter int WORD_SIZE    = 16,
   parameter int MEMORY_SIZE  = 16,
   parameter int LANE_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input logic          CLK,
   input logic          RST,
   memory_bank_if.slave bus
);

   localparam int LANES = lanes(WORD_SIZE, LANE_WIDTH);
   localparam int AW    = MEMORY_SIZE > 1 ? $clog2(MEMORY_SIZE) : 1;
   localparam logic [WORD_SIZE:0] MS = (WORD_SIZE + 1)'(MEMORY_SIZE);

   if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
      $error("memory_bank: READ_LATENCY must be 1 or 2");
   end
   if (WORD_SIZE % LANE_WIDTH != 0) begin : g_bad_lanes
      $error("memory_bank: WORD_SIZE must be a multiple of LANE_WIDTH");
   end

   state_t               state_q, state_d;
   logic [AW-1:0]        clr_q, clr_d;
   logic                 wr_err_q, wr_err_d;
   logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];
   logic                 acc, in_range, mem_we, pipe_v, pipe_e;
   logic [AW-1:0]        idx, mem_idx;
   logic [WORD_SIZE-1:0] rdata, mem_wdata, pipe_d;

   // the comparison is one bit wider than ADDR so high addresses never alias into range
   assign in_range = {1'b0, bus.ADDR} < MS;
   assign idx      = bus.ADDR[AW-1:0];
   assign acc      = state_q == RUN && bus.REQ;
   assign rdata    = in_range ? mem[idx] : '0;

   // clear sweep during INIT, then park in RUN until the next reset
   always_comb begin
      state_d  = state_q;
      clr_d    = clr_q;
      wr_err_d = acc && bus.W && !in_range;
      if (state_q == INIT) begin
         clr_d = clr_q + AW'(1);
         if (clr_q == AW'(MEMORY_SIZE - 1)) state_d = RUN;
      end
   end

   // control state, clear counter and the write-error pulse
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= INIT;
         clr_q    <= '0;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         clr_q    <= clr_d;
         wr_err_q <= wr_err_d;
      end
   end

   // single write port shared by the clear sweep and lane-masked stores
   always_comb begin
      mem_we    = state_q == INIT || (acc && bus.W && in_range);
      mem_idx   = state_q == INIT ? clr_q : idx;
      mem_wdata = state_q == INIT ? '0 : rdata;
      for (int l = 0; l < LANES; l++)
         if (state_q == RUN && bus.BE[l]) mem_wdata[l*LANE_WIDTH +: LANE_WIDTH] = bus.DATA_IN[l*LANE_WIDTH +: LANE_WIDTH];
   end

   // storage is deliberately not reset; the INIT sweep zeroes it instead
   always_ff @(posedge CLK) begin
      if (mem_we) mem[mem_idx] <= mem_wdata;
   end

   read_pipe #(
      .W     (WORD_SIZE),
      .DEPTH (READ_LATENCY)
   ) u_read_pipe (
      .CLK   (CLK),
      .RST   (RST),
      .v_in  (acc && !bus.W),
      .e_in  (acc && !bus.W && !in_range),
      .d_in  (rdata),
      .v_out (pipe_v),
      .e_out (pipe_e),
      .d_out (pipe_d)
   );

   assign bus.READY    = state_q == RUN;
   assign bus.VALID    = pipe_v;
   assign bus.DATA_OUT = pipe_d;
   assign bus.ERR      = pipe_e | wr_err_q;

endmodule
